// File: rtl/pulse_token_sched.sv
// Shares one external one-shot pulse generator between N_REQ requesters.
// Round-robin grant, token-bucket rate limit, busy handshake and idle gap.
module pulse_token_sched #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned BUCKET_DEPTH  = 4,
  parameter int unsigned REFILL_PERIOD = 16,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned ACK_TIMEOUT   = 4,
  localparam int unsigned OwnerW       = $clog2(N_REQ),
  localparam int unsigned TokW         = $clog2(BUCKET_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              busy,
  output logic              trig,
  output logic [N_REQ-1:0]  grant,
  output logic [OwnerW-1:0] owner,
  output logic [TokW-1:0]   tokens,
  output logic              active,
  output logic              err
);

  localparam int unsigned RefW    = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
  localparam int unsigned CntMax  = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam bit          GapEn   = (GAP_CYCLES != 0);
  localparam int unsigned GapLast = GapEn ? GAP_CYCLES - 1 : 0;

  localparam logic [N_REQ-1:0]  ReqOne   = N_REQ'(1);
  localparam logic [OwnerW-1:0] OwnerRst = OwnerW'(N_REQ - 1);
  localparam logic [TokW-1:0]   TokFull  = TokW'(BUCKET_DEPTH);
  localparam logic [TokW-1:0]   TokOne   = TokW'(1);
  localparam logic [RefW-1:0]   RefLast  = RefW'(REFILL_PERIOD - 1);
  localparam logic [RefW-1:0]   RefOne   = RefW'(1);
  localparam logic [CntW-1:0]   AckLast  = CntW'(ACK_TIMEOUT - 1);
  localparam logic [CntW-1:0]   GapLastC = CntW'(GapLast);
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StFire,
    StWaitHi,
    StWaitLo,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [TokW-1:0]   tokens_q, tokens_d;
  logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              refill;
  logic              consume;
  logic [N_REQ-1:0]  above_mask;
  logic [N_REQ-1:0]  masked_req;
  logic [N_REQ-1:0]  pick_req;
  logic [N_REQ-1:0]  pick_oh;
  logic [OwnerW-1:0] winner;

  // Round-robin: prefer requesters above the last owner, else wrap to the lowest one.
  always_comb begin
    above_mask = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      above_mask[i] = (i > 32'(owner_q));
    end
    masked_req = req & above_mask;
    pick_req   = (|masked_req) ? masked_req : req;
    pick_oh    = pick_req & (~pick_req + ReqOne);
    winner     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        winner = OwnerW'(i);
      end
    end
  end

  assign refill  = (ref_cnt_q == RefLast);
  assign consume = (state_q == StFire);

  // Refill and consume in the same cycle cancel out.
  always_comb begin
    ref_cnt_d = refill ? '0 : ref_cnt_q + RefOne;
    tokens_d  = tokens_q;
    if (refill && !consume) begin
      if (tokens_q != TokFull) begin
        tokens_d = tokens_q + TokOne;
      end
    end else if (consume && !refill) begin
      if (tokens_q != '0) begin
        tokens_d = tokens_q - TokOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= OwnerRst;
      tokens_q  <= TokFull;
      ref_cnt_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tokens_q  <= tokens_d;
      ref_cnt_q <= ref_cnt_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((|req) && (tokens_q != '0)) begin
          owner_d = winner;
          state_d = StFire;
        end
      end
      StFire: begin
        cnt_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (busy) begin
          state_d = StWaitLo;
        end else if (cnt_q == AckLast) begin
          // The token spent on a lost trigger stays spent.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GapEn ? StGap : StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWaitLo: begin
        if (!busy) begin
          cnt_d   = '0;
          state_d = GapEn ? StGap : StIdle;
        end
      end
      StGap: begin
        if (cnt_q == GapLastC) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    trig   = (state_q == StFire);
    grant  = trig ? (ReqOne << owner_q) : '0;
    active = (state_q != StIdle);
    err    = err_q;
    owner  = owner_q;
    tokens = tokens_q;
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_grant_trig:   assert property (@(posedge clk) disable iff (!rst_n) (|grant) == trig);
  a_tokens_max:   assert property (@(posedge clk) disable iff (!rst_n) tokens <= TokFull);
  a_err_quiet:    assert property (@(posedge clk) disable iff (!rst_n) err |-> !trig);

endmodule

// File: tb/tb_pulse_token_sched.sv
// Bench for pulse_token_sched: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model built from the arbitration and bucket rules.
module tb_pulse_token_sched;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;
  localparam int unsigned R = 16;
  localparam int unsigned G = 2;
  localparam int unsigned A = 4;

  localparam int PI = 0;
  localparam int PF = 1;
  localparam int PH = 2;
  localparam int PL = 3;
  localparam int PG = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       busy;
  logic       trig;
  logic [3:0] grant;
  logic [1:0] owner;
  logic [2:0] tokens;
  logic       active;
  logic       err;

  pulse_token_sched #(
    .N_REQ        (N),
    .BUCKET_DEPTH (D),
    .REFILL_PERIOD(R),
    .GAP_CYCLES   (G),
    .ACK_TIMEOUT  (A)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .busy  (busy),
    .trig  (trig),
    .grant (grant),
    .owner (owner),
    .tokens(tokens),
    .active(active),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Shared one-shot: y rises the cycle after trig and stays high os_len cycles.
  int   os_len;
  bit   os_en;
  logic busy_drv;
  int   os_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) os_cnt <= 0;
    else if (trig) os_cnt <= os_len;
    else if (os_cnt > 0) os_cnt <= os_cnt - 1;
  end
  assign busy = os_en ? (os_cnt != 0) : busy_drv;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_phase, m_owner, m_tok, m_age, m_cycle;
  bit m_err;
  int cyc_n;

  logic [11:0] dut_vec;
  assign dut_vec = {trig, grant, owner, tokens, active, err};

  function automatic logic [11:0] exp_vec();
    logic [3:0] g;
    g = (m_phase == PF) ? 4'(1 << m_owner) : 4'b0000;
    return {m_phase == PF, g, 2'(m_owner), 3'(m_tok), m_phase != PI, m_err};
  endfunction

  task automatic model_reset();
    m_phase = PI;
    m_owner = N - 1;
    m_tok   = D;
    m_age   = 0;
    m_cycle = 0;
    m_err   = 1'b0;
    cyc_n   = 0;
  endtask

  task automatic model_step();
    int  refill, consume, idx;
    bit  found;
    refill  = ((m_cycle % R) == R - 1) ? 1 : 0;
    consume = (m_phase == PF) ? 1 : 0;
    m_err   = 1'b0;
    case (m_phase)
      PI: if (req != 0 && m_tok > 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_owner + k) % N;
          if (!found && req[idx]) begin
            found   = 1'b1;
            m_owner = idx;
          end
        end
        m_phase = PF;
      end
      PF: begin m_phase = PH; m_age = 0; end
      PH: begin
        if (busy) m_phase = PL;
        else if (m_age + 1 >= A) begin
          m_err = 1'b1; m_age = 0; m_phase = (G > 0) ? PG : PI;
        end else m_age++;
      end
      PL: if (!busy) begin m_age = 0; m_phase = (G > 0) ? PG : PI; end
      PG: begin m_age++; if (m_age >= G) m_phase = PI; end
      default: m_phase = PI;
    endcase
    m_tok = m_tok + refill - consume;
    if (m_tok > D) m_tok = D;
    m_cycle++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
  endtask

  // Entered one time unit after a rising edge; leaves the bench in cycle 0.
  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    busy_drv = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; busy_drv = 1'b0; os_en = 1'b1; os_len = 6;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (trig !== 1'b0) begin n_errors++; $display("FAIL reset_trig got %b want 0", trig); end
    n_checks++; if (grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_checks++; if (owner !== 2'd3) begin n_errors++; $display("FAIL reset_owner got %0d want 3", owner); end
    n_checks++; if (tokens !== 3'd4) begin n_errors++; $display("FAIL reset_tokens got %0d want 4", tokens); end
    n_checks++; if (active !== 1'b0) begin n_errors++; $display("FAIL reset_active got %b want 0", active); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", err); end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    os_en = 1'b1; os_len = 6; req = 4'b0001;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; $display("FAIL single_model c%0d got %b want %b", c, dut_vec, exp_vec());
      end
      if (c == 1 || c == 12) begin
        n_checks++;
        if (trig !== 1'b1 || grant !== 4'b0001) begin
          n_errors++; $display("FAIL single_trig c%0d got %b/%b want 1/0001", c, trig, grant);
        end
      end
      if (c == 2 || c == 13) begin
        n_checks++;
        if (tokens !== ((c == 2) ? 3'd3 : 3'd2)) begin
          n_errors++; $display("FAIL single_tokens c%0d got %0d want %0d", c, tokens, (c == 2) ? 3 : 2);
        end
      end
      if (c == 11) begin
        n_checks++;
        if (active !== 1'b0) begin n_errors++; $display("FAIL single_idle c11 got %b want 0", active); end
      end
    end
  endtask

  task automatic test_all_req();
    logic [3:0] gseq[$];
    int zero_c, after_zero;
    do_reset();
    os_en = 1'b1; os_len = 1; req = 4'b1111;
    zero_c = -1; after_zero = -1;
    for (int c = 1; c <= 80; c++) begin
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; $display("FAIL allreq_model c%0d got %b want %b", c, dut_vec, exp_vec());
      end
      if (trig === 1'b1) gseq.push_back(grant);
      if (tokens === 3'd0 && zero_c < 0) zero_c = c;
      if (trig === 1'b1 && zero_c >= 0 && after_zero < 0) after_zero = c;
    end
    n_checks++;
    if (gseq.size() < 5) begin
      n_errors++; $display("FAIL allreq_count got %0d want >=5", gseq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (gseq[i] !== 4'(1 << (i % 4))) begin
          n_errors++; $display("FAIL allreq_order #%0d got %b want %b", i, gseq[i], 4'(1 << (i % 4)));
        end
      end
    end
    n_checks++;
    if (zero_c < 0 || after_zero < 0 || (after_zero % R) != 1) begin
      n_errors++; $display("FAIL allreq_refill_wait zero_c %0d next_trig %0d want trig at 16k+1", zero_c, after_zero);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    os_en = 1'b0; busy_drv = 1'b0; req = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; $display("FAIL timeout_model c%0d got %b want %b", c, dut_vec, exp_vec());
      end
      if (c == 1 || c == 9) begin
        n_checks++;
        if (trig !== 1'b1 || grant !== 4'b0100) begin
          n_errors++; $display("FAIL timeout_trig c%0d got %b/%b want 1/0100", c, trig, grant);
        end
      end
      if (c >= 2 && c <= 7) begin
        n_checks++;
        if (err !== (c == 6) || active !== 1'b1) begin
          n_errors++; $display("FAIL timeout_err c%0d got err %b act %b want err %b act 1", c, err, active, c == 6);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (tokens !== 3'd3) begin n_errors++; $display("FAIL timeout_tokens got %0d want 3", tokens); end
      end
    end
  endtask

  task automatic test_refill();
    int prev, guard;
    do_reset();
    os_en = 1'b1; os_len = 1; req = 4'b1111;
    guard = 0;
    while (tokens !== 3'd0 && guard < 100) begin
      cyc();
      guard++;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; $display("FAIL refill_drain_model c%0d got %b want %b", cyc_n, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (tokens !== 3'd0) begin n_errors++; $display("FAIL refill_drain got %0d want 0", tokens); end
    req = 4'b0000;
    prev = tokens;
    for (int c = 0; c < 80; c++) begin
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; $display("FAIL refill_model c%0d got %b want %b", cyc_n, dut_vec, exp_vec());
      end
      if (int'(tokens) != prev) begin
        n_checks++;
        if (int'(tokens) != prev + 1 || (cyc_n % R) != 0) begin
          n_errors++; $display("FAIL refill_step c%0d got %0d from %0d want +1 at 16k", cyc_n, tokens, prev);
        end
        prev = tokens;
      end
    end
    n_checks++;
    if (tokens !== 3'd4) begin n_errors++; $display("FAIL refill_sat got %0d want 4", tokens); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    os_en = 1'b1; os_len = 6; req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; $display("FAIL rstmid_model c%0d got %b want %b", c, dut_vec, exp_vec());
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (trig !== 1'b0 || grant !== 4'b0 || active !== 1'b0 || tokens !== 3'd4 || owner !== 2'd3) begin
      n_errors++;
      $display("FAIL rstmid_async got t%b g%b a%b tok%0d own%0d want t0 g0000 a0 tok4 own3",
               trig, grant, active, tokens, owner);
    end
    req = 4'b1010;
    model_reset();
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; $display("FAIL rstmid_after_model c%0d got %b want %b", c, dut_vec, exp_vec());
      end
      if (c == 1) begin
        n_checks++;
        if (grant !== 4'b0010) begin n_errors++; $display("FAIL rstmid_first_grant got %b want 0010", grant); end
      end
    end
  endtask

  task automatic test_one_cycle_req();
    int extra;
    do_reset();
    os_en = 1'b1; os_len = 3; req = 4'b0010;
    cyc();
    req = 4'b0000;
    n_checks++;
    if (trig !== 1'b1 || grant !== 4'b0010) begin
      n_errors++; $display("FAIL short_req_grant got %b/%b want 1/0010", trig, grant);
    end
    extra = 0;
    for (int c = 2; c <= 16; c++) begin
      cyc();
      if (trig === 1'b1) extra++;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; $display("FAIL short_req_model c%0d got %b want %b", c, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (extra != 0) begin n_errors++; $display("FAIL short_req_extra got %0d trigs want 0", extra); end
  endtask

  task automatic test_random();
    do_reset();
    os_en = 1'b1; os_len = 4;
    for (int c = 1; c <= 1500; c++) begin
      if ((c % 100) == 1) begin
        os_en  = ($urandom_range(0, 3) != 0);
        os_len = $urandom_range(1, 8);
      end
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if (!os_en) busy_drv = ($urandom_range(0, 3) == 0);
      cyc();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; $display("FAIL random_model c%0d got %b want %b", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_timeout();
    test_refill();
    test_reset_mid();
    test_one_cycle_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
